// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus initiator: op encodings, T-state encoding and refresh address.
package z80_bus_pkg;

    typedef enum logic [2:0] {
        MEM_RD  = 3'd0,
        MEM_WR  = 3'd1,
        IO_RD   = 3'd2,
        IO_WR   = 3'd3,
        OPFETCH = 3'd4,
        INTA    = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        T1,
        T2,
        TW,
        T3,
        T4
    } tstate_e;

    localparam logic [8:0] RFSH_ADDR_HI = 9'h000;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

endpackage

// File: rtl/z80_wait_ctr.sv
// Wait-state bookkeeping: forced-TW countdown, wait_n sampling and the timeout counter.
module z80_wait_ctr #(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] forced_init,
    input  logic       in_t2,
    input  logic       in_tw,
    input  logic       wait_n,
    output logic       more_wait,
    output logic       timeout,
    output logic       forced_tw
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [7:0] forced_q, forced_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sample;

    // Forced waits skip sampling; wait_n is taken at the end of T2 when none are
    // forced, otherwise at the end of the last forced TW and every TW after it.
    assign sample    = (in_t2 && forced_q == 8'd0) || (in_tw && forced_q <= 8'd1);
    assign forced_tw = forced_q != 8'd0;
    assign timeout   = in_tw && sample && !wait_n && (cnt_q == TIMEOUT_LAST);
    assign more_wait = (in_t2 && forced_q != 8'd0) || (in_tw && forced_q > 8'd1) ||
                       (sample && !wait_n && !timeout);

    always_comb begin
        forced_d = forced_q;
        cnt_d    = cnt_q;
        if (start) begin
            forced_d = forced_init;
            cnt_d    = 8'd0;
        end else if (in_tw) begin
            if (forced_q != 8'd0) forced_d = forced_q - 8'd1;
            if (sample && !wait_n) cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            forced_q <= 8'd0;
            cnt_q    <= 8'd0;
        end else begin
            forced_q <= forced_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus initiator: one request becomes one T-state-accurate bus cycle (one clk per T-state).
// Optional refresh during opcode fetch T3/T4 is enabled by defining Z80_BUS_MASTER_RFSH_EN.
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int unsigned IO_AUTO_WAITS   = 1,
    parameter int unsigned INTA_AUTO_WAITS = 2,
    parameter int unsigned WAIT_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        dout_oe,
    input  logic [7:0]  din,
    input  logic        wait_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        m1_n,
    output logic        rfsh_n
);

    tstate_e     state_q, state_d;
    op_e         op_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        accept, start, capture;
    logic        more_wait, timeout, forced_tw;
    logic [7:0]  forced_init;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign start     = accept && op_is_valid(req_op);

    always_comb begin
        forced_init = 8'd0;
        if (req_op == IO_RD || req_op == IO_WR) forced_init = 8'(IO_AUTO_WAITS);
        else if (req_op == INTA)                forced_init = 8'(INTA_AUTO_WAITS);
    end

    z80_wait_ctr #(
        .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) u_wait_ctr (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .forced_init(forced_init),
        .in_t2      (state_q == T2),
        .in_tw      (state_q == TW),
        .wait_n     (wait_n),
        .more_wait  (more_wait),
        .timeout    (timeout),
        .forced_tw  (forced_tw)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = T1;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            T1: state_d = T2;
            T2: state_d = more_wait ? TW : T3;
            TW: begin
                if (timeout) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d = more_wait ? TW : T3;
                end
            end
            T3: begin
                if (op_q == OPFETCH) begin
                    state_d = T4;
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            T4: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Opcode fetch samples the bus as it leaves T2/TW; other reads sample at the end of T3.
    assign capture = ((state_q == T3) && (op_q == MEM_RD || op_q == IO_RD || op_q == INTA)) ||
                     ((op_q == OPFETCH) && (state_q == T2 || state_q == TW) && (state_d == T3));

    always_comb begin
        rdata_d = rdata_q;
        if (accept)       rdata_d = 8'h00;
        else if (capture) rdata_d = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= MEM_RD;
            addr_q      <= 16'h0000;
            dout_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            if (start) begin
                op_q   <= op_e'(req_op);
                addr_q <= (req_op == INTA) ? 16'h0000 : req_addr;
                dout_q <= (req_op == MEM_WR || req_op == IO_WR) ? req_wdata : 8'h00;
            end
        end
    end

`ifdef Z80_BUS_MASTER_RFSH_EN
    logic [6:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 7'h00;
        end else if (state_q == T4) begin
            r_q <= r_q + 7'd1;
        end
    end
`endif

    always_comb begin
        addr    = addr_q;
        dout    = dout_q;
        dout_oe = 1'b0;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        mreq_n  = 1'b1;
        iorq_n  = 1'b1;
        m1_n    = 1'b1;
        rfsh_n  = 1'b1;
        if (state_q != IDLE) begin
            case (op_q)
                MEM_RD: begin
                    mreq_n = 1'b0;
                    rd_n   = 1'b0;
                end
                MEM_WR: begin
                    mreq_n  = 1'b0;
                    dout_oe = 1'b1;
                    if (state_q != T1) wr_n = 1'b0;
                end
                IO_RD: begin
                    if (state_q != T1) begin
                        iorq_n = 1'b0;
                        rd_n   = 1'b0;
                    end
                end
                IO_WR: begin
                    dout_oe = 1'b1;
                    if (state_q != T1) begin
                        iorq_n = 1'b0;
                        wr_n   = 1'b0;
                    end
                end
                OPFETCH: begin
                    if (state_q == T1 || state_q == T2 || state_q == TW) begin
                        m1_n   = 1'b0;
                        mreq_n = 1'b0;
                        rd_n   = 1'b0;
                    end
`ifdef Z80_BUS_MASTER_RFSH_EN
                    else begin
                        addr   = {RFSH_ADDR_HI, r_q};
                        rfsh_n = 1'b0;
                        if (state_q == T3) mreq_n = 1'b0;
                    end
`endif
                end
                INTA: begin
                    m1_n = 1'b0;
                    if ((state_q == TW && !forced_tw) || state_q == T3) iorq_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master: strobe timing, waits, timeout, refresh and mid-cycle reset.
module tb_z80_bus_master;
    import z80_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [15:0] addr;
    logic [7:0]  dout, din;
    logic        dout_oe, wait_n;
    logic        rd_n, wr_n, mreq_n, iorq_n, m1_n, rfsh_n;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    z80_bus_master #(
        .IO_AUTO_WAITS  (1),
        .INTA_AUTO_WAITS(2),
        .WAIT_TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .addr     (addr),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .din      (din),
        .wait_n   (wait_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .mreq_n   (mreq_n),
        .iorq_n   (iorq_n),
        .m1_n     (m1_n),
        .rfsh_n   (rfsh_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it until rsp_valid (k=1 is the T1 cycle).
    // wait_n is held low for cycles 2 .. 2+wlo-1.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] di, input int wlo,
                          output int lat, output int n_rd, output int n_wr, output int n_mreq,
                          output int n_iorq, output int n_m1, output int n_rfsh, output int n_oe,
                          output logic [15:0] a_t1, output logic [15:0] a_t3,
                          output logic [7:0] dout_seen, output logic [7:0] rdata,
                          output logic err);
        int k;
        n_rd = 0; n_wr = 0; n_mreq = 0; n_iorq = 0; n_m1 = 0; n_rfsh = 0; n_oe = 0;
        a_t1 = 16'hxxxx; a_t3 = 16'hxxxx; dout_seen = 8'hxx;
        req_op = op; req_addr = a; req_wdata = wd; din = di; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 600) begin
            wait_n = !(k >= 2 && k < 2 + wlo);
            if (!rd_n)    n_rd++;
            if (!wr_n)    begin n_wr++; dout_seen = dout; end
            if (!mreq_n)  n_mreq++;
            if (!iorq_n)  n_iorq++;
            if (!m1_n)    n_m1++;
            if (!rfsh_n)  n_rfsh++;
            if (dout_oe)  n_oe++;
            if (k == 1)   a_t1 = addr;
            if (k == 3)   a_t3 = addr;
            @(posedge clk); #1;
            k++;
        end
        wait_n = 1'b1;
        lat   = rsp_valid ? k : -1;
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh, n_oe;
        logic [15:0] a_t1, a_t3;
        logic [7:0]  dseen, rdata;
        logic        err;
        int          seen;

        rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0000; req_wdata = 8'h00;
        din = 8'h00; wait_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset strobes", {rd_n, wr_n, mreq_n, iorq_n, m1_n, rfsh_n}, 6'b111111);
        check("reset addr", addr, 16'h0000);
        check("reset dout", {dout_oe, dout}, 9'h000);
        check("reset rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready after reset", req_ready, 1'b1);

        // 1: MEM_RD, no waits
        run_op(MEM_RD, 16'h6000, 8'h00, 8'hA5, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("memrd latency", lat, 4);
        check("memrd rd_n low", n_rd, 3);
        check("memrd mreq_n low", n_mreq, 3);
        check("memrd other strobes", n_wr + n_iorq + n_m1 + n_oe, 0);
        check("memrd addr", a_t1, 16'h6000);
        check("memrd rdata/err", {rdata, err}, {8'hA5, 1'b0});
        check("rsp_valid one pulse", rsp_valid, 1'b0);

        // 2: MEM_WR with two low wait samples
        run_op(MEM_WR, 16'h7F00, 8'h3C, 8'hEE, 2, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("memwr latency", lat, 6);
        check("memwr wr_n low", n_wr, 4);
        check("memwr mreq_n low", n_mreq, 5);
        check("memwr dout_oe", n_oe, 5);
        check("memwr dout", dseen, 8'h3C);
        check("memwr rdata/err", {rdata, err}, {8'h00, 1'b0});

        // 3a: IO_RD, one forced wait
        run_op(IO_RD, 16'h0010, 8'h00, 8'h77, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("iord latency", lat, 5);
        check("iord iorq_n low", n_iorq, 3);
        check("iord rd_n low", n_rd, 3);
        check("iord no mreq", n_mreq, 0);
        check("iord addr", a_t1, 16'h0010);
        check("iord rdata/err", {rdata, err}, {8'h77, 1'b0});

        // 3b: IO_WR
        run_op(IO_WR, 16'h00FE, 8'h99, 8'h00, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("iowr latency", lat, 5);
        check("iowr wr/iorq/oe", {8'(n_wr), 8'(n_iorq), 8'(n_oe)}, {8'd3, 8'd3, 8'd4});
        check("iowr dout", dseen, 8'h99);

        // 3c: INTA, two forced waits
        run_op(INTA, 16'h1234, 8'h00, 8'hFF, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("inta latency", lat, 6);
        check("inta m1_n low", n_m1, 5);
        check("inta iorq_n low", n_iorq, 1);
        check("inta no rd/mreq", n_rd + n_mreq, 0);
        check("inta addr", a_t1, 16'h0000);
        check("inta rdata/err", {rdata, err}, {8'hFF, 1'b0});

        // 4: wait_n stuck low, timeout after 4 TW
        run_op(MEM_RD, 16'h2222, 8'h00, 8'h5A, 1000, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1,
               n_rfsh, n_oe, a_t1, a_t3, dseen, rdata, err);
        check("timeout latency", lat, 7);
        check("timeout rd_n low", n_rd, 6);
        check("timeout rdata/err", {rdata, err}, {8'h00, 1'b1});

        // Undefined op encoding
        run_op(3'd6, 16'h3333, 8'h00, 8'h11, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("badop latency", lat, 1);
        check("badop err", {rdata, err}, {8'h00, 1'b1});

        // 5: 129 opcode fetches, refresh counter wraps
        for (int i = 0; i < 129; i++) begin
            run_op(OPFETCH, 16'h4000 + 16'(i), 8'h00, 8'(i) ^ 8'h55, 0, lat, n_rd, n_wr, n_mreq,
                   n_iorq, n_m1, n_rfsh, n_oe, a_t1, a_t3, dseen, rdata, err);
            check("fetch latency", lat, 5);
            check("fetch m1/rd", {8'(n_m1), 8'(n_rd)}, {8'd2, 8'd2});
            check("fetch rdata", {rdata, err}, {8'(i) ^ 8'h55, 1'b0});
`ifdef Z80_BUS_MASTER_RFSH_EN
            check("fetch rfsh addr", a_t3, {9'h000, 7'(i)});
            check("fetch rfsh/mreq", {8'(n_rfsh), 8'(n_mreq)}, {8'd2, 8'd3});
`else
            check("fetch addr held", a_t3, 16'h4000 + 16'(i));
            check("fetch rfsh/mreq", {8'(n_rfsh), 8'(n_mreq)}, {8'd0, 8'd2});
`endif
        end

        // 6: reset during MEM_WR T2
        req_op = MEM_WR; req_addr = 16'h5555; req_wdata = 8'hC3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre-reset wr_n", {wr_n, mreq_n, dout_oe}, 3'b001);
        rst = 1'b1;
        #1;
        check("mid reset strobes", {rd_n, wr_n, mreq_n, iorq_n, m1_n, dout_oe}, 6'b111110);
        check("mid reset addr/dout", {addr, dout}, 24'h000000);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("no rsp after reset", seen, 0);
        check("ready after mid reset", req_ready, 1'b1);
        run_op(MEM_RD, 16'h0102, 8'h00, 8'h3E, 0, lat, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_rfsh,
               n_oe, a_t1, a_t3, dseen, rdata, err);
        check("recover latency", lat, 4);
        check("recover rdata", {rdata, err}, {8'h3E, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
